// File: rtl/pwm_duty_ramp_ctrl_pkg.sv
// Shared definitions for the PWM duty ramp controller and the PWM generator.
// Holds the ramp state encoding and the default duty-code constants.
package pwm_pkg;

    localparam int DUTY_W           = 4;
    localparam int DUTY_MAX         = 10;
    localparam int DUTY_INIT        = 5;
    localparam int PERIODS_PER_STEP = 4;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RAMP_UP   = 2'd1,
        RAMP_DOWN = 2'd2
    } ramp_state_t;

endpackage

// File: rtl/pwm_duty_ramp_ctrl_if.sv
// Host-side request bus of the duty ramp controller: step pulses and the
// absolute target load handshake. The host drives the master side, the
// controller takes the slave side.
interface pwm_duty_ramp_ctrl_if #(
    parameter int DUTY_W = pwm_pkg::DUTY_W
);
    logic              inc_req;
    logic              dec_req;
    logic              tgt_valid;
    logic [DUTY_W-1:0] tgt_duty;
    logic              tgt_ready;

    modport master (
        output inc_req, dec_req, tgt_valid, tgt_duty,
        input  tgt_ready
    );

    modport slave (
        input  inc_req, dec_req, tgt_valid, tgt_duty,
        output tgt_ready
    );
endinterface

// File: rtl/pwm_duty_ramp_ctrl_step_timer.sv
// Ramp step prescaler: counts pwm_wrap pulses while a ramp is running and
// strobes once every PERIODS_PER_STEP wraps. Clear restarts the step timing.
module pwm_step_timer #(
    parameter int PERIODS_PER_STEP = pwm_pkg::PERIODS_PER_STEP
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    input  logic run,
    input  logic wrap,
    output logic step
);
    localparam int CNT_W = (PERIODS_PER_STEP > 1) ? $clog2(PERIODS_PER_STEP) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIODS_PER_STEP - 1);

    logic [CNT_W-1:0] cnt;

    assign step = en & run & wrap & (cnt == LAST);

    // Wrap counter; clear wins over counting, everything frozen when disabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (en) begin
            if (clr) begin
                cnt <= '0;
            end else if (run && wrap) begin
                cnt <= (cnt == LAST) ? '0 : cnt + CNT_W'(1);
            end
        end
    end
endmodule

// File: rtl/pwm_duty_ramp_ctrl.sv
// PWM duty ramp controller: takes step/load requests into a target register
// and slews the applied duty toward it by one code per step strobe, which
// only ever fires on a PWM period wrap so the comparator never glitches.
// Optional macro PWM_SOFTSTART_EN: leave reset at duty 0 and ramp up to
// DUTY_INIT instead of starting directly at DUTY_INIT.
module pwm_duty_ramp_ctrl
    import pwm_pkg::*;
#(
    parameter int DUTY_W           = pwm_pkg::DUTY_W,
    parameter int DUTY_MAX         = pwm_pkg::DUTY_MAX,
    parameter int DUTY_INIT        = pwm_pkg::DUTY_INIT,
    parameter int PERIODS_PER_STEP = pwm_pkg::PERIODS_PER_STEP
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ena,
    input  logic                  pwm_wrap,
    pwm_duty_ramp_ctrl_if.slave   host,
    output logic [DUTY_W-1:0]     duty_out,
    output logic                  busy,
    output logic                  at_target,
    output logic                  sat_pulse
);
    localparam logic [DUTY_W-1:0] MAX_CODE  = DUTY_W'(DUTY_MAX);
    localparam logic [DUTY_W-1:0] INIT_CODE = DUTY_W'(DUTY_INIT);

    ramp_state_t       state;
    ramp_state_t       next_state;
    logic [DUTY_W-1:0] target;
    logic [DUTY_W-1:0] target_next;
    logic [DUTY_W-1:0] duty;
    logic [DUTY_W-1:0] duty_next;
    logic              sat_next;
    logic              div_clr;
    logic              step;

    assign host.tgt_ready = ena;
    assign duty_out       = duty;
    assign busy           = (state != IDLE);
    assign at_target      = (duty == target);

    // Next ramp direction from the registered target/duty comparison
    always_comb begin
        next_state = IDLE;
        if (duty < target) begin
            next_state = RAMP_UP;
        end else if (duty > target) begin
            next_state = RAMP_DOWN;
        end
    end

    // Any state change restarts the step timing
    assign div_clr = (next_state != state);

    pwm_step_timer #(
        .PERIODS_PER_STEP (PERIODS_PER_STEP)
    ) u_step_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (ena),
        .clr   (div_clr),
        .run   (state != IDLE),
        .wrap  (pwm_wrap),
        .step  (step)
    );

    // Duty step toward the current (old) target; stepping only in the
    // direction that still closes the gap makes overshoot impossible
    always_comb begin
        duty_next = duty;
        if (step) begin
            if (state == RAMP_UP && duty < target) begin
                duty_next = duty + DUTY_W'(1);
            end else if (state == RAMP_DOWN && duty > target) begin
                duty_next = duty - DUTY_W'(1);
            end
        end
    end

    // Target update: absolute load beats inc/dec, clamping flags saturation
    always_comb begin
        target_next = target;
        sat_next    = 1'b0;
        if (host.tgt_valid) begin
            if (host.tgt_duty > MAX_CODE) begin
                target_next = MAX_CODE;
                sat_next    = 1'b1;
            end else begin
                target_next = host.tgt_duty;
            end
        end else if (host.inc_req && !host.dec_req) begin
            if (target >= MAX_CODE) begin
                sat_next = 1'b1;
            end else begin
                target_next = target + DUTY_W'(1);
            end
        end else if (host.dec_req && !host.inc_req) begin
            if (target == '0) begin
                sat_next = 1'b1;
            end else begin
                target_next = target - DUTY_W'(1);
            end
        end
    end

    // Controller registers; ena low freezes everything
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
`ifdef PWM_SOFTSTART_EN
            duty  <= '0;
            state <= RAMP_UP;
`else
            duty  <= INIT_CODE;
            state <= IDLE;
`endif
            target    <= INIT_CODE;
            sat_pulse <= 1'b0;
        end else if (ena) begin
            state     <= next_state;
            target    <= target_next;
            duty      <= duty_next;
            sat_pulse <= sat_next;
        end
    end
endmodule
